pixel_write_queue: RTL and testbench
====================================

# pixel_write_queue

Elastic buffer between the line rasteriser's pixel output and the framebuffer write port. It accepts plotted pixels with a valid/ready handshake and queues them in a FIFO. Writes are issued to the framebuffer only while the framebuffer grants write access, so drawing is decoupled from active-video timing. It also reports queue occupancy and a flush-complete indication to the drawing sequencer.

## Interface
- DEPTH, 16, FIFO entries; power of two, minimum 4
- H_RES, 800, visible width in pixels (clip bound)
- V_RES, 600, visible height in pixels (clip bound)
- CNT_W, 16, drop counter width
- clk  in  1  single clock for all logic
- rst  in  1  reset: asynchronous, active-high; one clock domain
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  queue can accept; equals (count != DEPTH)
- in_x  in  11  pixel column
- in_y  in  11  pixel row
- in_color  in  1  pixel colour
- flush  in  1  pulse: discard all queued pixels
- fb_allow  in  1  framebuffer write grant (typically ~in_display)
- fb_we  out  1  registered write strobe
- fb_x  out  11  registered write column
- fb_y  out  11  registered write row
- fb_color  out  1  registered write colour
- count  out  $clog2(DEPTH)+1  current occupancy
- empty  out  1  count == 0
- drop_cnt  out  CNT_W  clipped-pixel counter (see Configuration)

## Operation
- Push: the queue pushes when in_valid && in_ready. Under clipping, an off-screen pixel is consumed without being stored.
- Pop: the queue pops when state is DRAIN, fb_allow == 1 and count != 0. The popped entry is registered onto fb_x/fb_y/fb_color, and fb_we = 1 in the next cycle. In all other cycles fb_we = 0, and fb_x/fb_y/fb_color hold their last values.
- Simultaneous push and pop: count is unchanged. The pointers advance independently and wrap modulo DEPTH.
- Full: in_ready = 0 even if a pop occurs in the same cycle. There is no bypass.
- Empty: no pop. fb_we = 0 in the following cycle.
- FSM states:
  - IDLE: empty. Goes to DRAIN on count != 0.
  - DRAIN: popping. Goes to STALL when fb_allow == 0 and count != 0. Goes to IDLE when count reaches 0 with no push.
  - STALL: holding. Goes to DRAIN when fb_allow == 1.
  - FLUSH: entered from any state on flush.
- FLUSH behaviour:
  - On entry, read/write pointers and count clear; in_ready = 0 for that cycle; no pop.
  - Next cycle goes to IDLE.
  - A push coincident with the flush pulse is discarded.
- fb_allow falling in the same cycle as a pop: that pop still completes, so fb_we rises in the next cycle regardless of fb_allow. The framebuffer must tolerate one write after revoking the grant.
- Reset values: fb_we = 0; fb_x = 0; fb_y = 0; fb_color = 0; count = 0; empty = 1; in_ready = 1; drop_cnt = 0; state = IDLE.
- Reset mid-operation: all queued pixels are discarded immediately (asynchronous). Any fb_we in flight is cleared.

## Timing
- Minimum latency, accept to fb_we: 2 cycles. Example: accept at edge N, pop decided in cycle N+1, fb_we high in cycle N+2.
- Sustained throughput: 1 pixel/cycle when fb_allow is held high and upstream is always valid.
- in_ready, empty and count derive only from registered state; there is no combinational path from in_valid.
- flush to empty = 1: 1 cycle.

## Configuration
- PIXEL_CLIP_EN defined:
  - A pixel with in_x >= H_RES or in_y >= V_RES is accepted (handshake completes) but not stored.
  - drop_cnt increments by 1 for each such pixel and saturates at all-ones.
  - flush does not clear drop_cnt; only rst does.
- PIXEL_CLIP_EN undefined:
  - All accepted pixels are stored.
  - drop_cnt is tied to 0.
  - H_RES/V_RES are unused.

## Structure
- Shared package gfx_pkg:
  - COORD_W = 11, H_RES, V_RES
  - pixel_t packed struct {x, y, color}
  - pwq_state_t enum {IDLE, DRAIN, STALL, FLUSH}
- Sub-module pixel_fifo: storage array of pixel_t with read/write pointers and count, plus a clear input used by flush.
- The top level holds the FSM, the clip logic and the output registers.

## Test plan
- Single pixel (x=100, y=100, color=1) with fb_allow=1: fb_we high exactly 2 cycles after accept, fb_x=100, fb_y=100; empty=1 afterwards.
- Push 20 pixels back-to-back with fb_allow=0 (DEPTH=16): in_ready drops after 16 accepts and count=16. Then raise fb_allow: 16 consecutive fb_we cycles in FIFO order, and in_ready returns 1 one cycle after the first pop.
- Continuous stream with fb_allow=1: count stays ≤1 and one fb_we per cycle is sustained. Toggle fb_allow low for 5 cycles: state STALL, no fb_we beyond the single overhang write, no lost or duplicated pixels.
- Queue 8 pixels, pulse flush coincident with a push: the next cycle shows count=0, empty=1, no fb_we, and the coincident pixel is never written.
- With PIXEL_CLIP_EN, push (799,599), (800,10), (10,600): only (799,599) is written and drop_cnt=2. Without PIXEL_CLIP_EN, all three are written and drop_cnt=0.
- Assert rst mid-drain with 5 pixels queued: outputs return to reset values asynchronously, and after release in_ready=1 and empty=1.

Source files
------------

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared pixel types, screen bounds and queue state encoding
package gfx_pkg;

    localparam int COORD_W = 11;
    localparam int H_RES   = 800;
    localparam int V_RES   = 600;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               color;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } pwq_state_t;

endpackage

// File: rtl/pixel_write_queue_if.sv
// rtl/pixel_write_queue_if.sv - rasteriser pixel input, framebuffer write port and queue status
interface pixel_write_queue_if
    import gfx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [COORD_W-1:0]     in_x;
    logic [COORD_W-1:0]     in_y;
    logic                   in_color;
    logic                   flush;
    logic                   fb_allow;
    logic                   fb_we;
    logic [COORD_W-1:0]     fb_x;
    logic [COORD_W-1:0]     fb_y;
    logic                   fb_color;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic [CNT_W-1:0]       drop_cnt;

    modport master (
        output in_valid, in_x, in_y, in_color, flush, fb_allow,
        input  in_ready, fb_we, fb_x, fb_y, fb_color, count, empty, drop_cnt
    );

    modport slave (
        input  in_valid, in_x, in_y, in_color, flush, fb_allow,
        output in_ready, fb_we, fb_x, fb_y, fb_color, count, empty, drop_cnt
    );

endinterface

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - pixel storage ring with occupancy count and synchronous clear
module pixel_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  pixel_t                 din,
    output pixel_t                 dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    pixel_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide so the increments wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/pixel_write_queue.sv
// rtl/pixel_write_queue.sv - elastic pixel queue feeding the framebuffer while writes are granted
// Optional off-screen clipping with drop counter when PIXEL_CLIP_EN is defined.
module pixel_write_queue
    import gfx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int H_RES = gfx_pkg::H_RES,
    parameter int V_RES = gfx_pkg::V_RES,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    pixel_write_queue_if.slave bus
);
    localparam int                 CW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]      FULL  = CW'(DEPTH);
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);
`ifdef PIXEL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    pwq_state_t         state_q, state_d;
    logic [CW-1:0]      count;
    pixel_t             din, head;
    logic               ready, push, store, pop, off_screen, will_empty;
    logic               fb_we_q, fb_color_q;
    logic [COORD_W-1:0] fb_x_q, fb_y_q;

    // Ready depends only on registered state; the flush cycle refuses input.
    assign ready      = (state_q != FLUSH) && (count != FULL);
    assign off_screen = CLIP_EN && ((bus.in_x >= X_LIM) || (bus.in_y >= Y_LIM));
    assign push       = bus.in_valid && ready;
    assign store      = push && !off_screen && !bus.flush;
    assign pop        = (state_q == DRAIN) && bus.fb_allow && (count != '0) && !bus.flush;
    assign will_empty = !store && ((count == '0) || ((count == CW'(1)) && pop));
    assign din        = '{x: bus.in_x, y: bus.in_y, color: bus.in_color};

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .push  (store),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Leaving IDLE on a store keeps a continuous stream at one entry of occupancy.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if ((count != '0) || store) state_d = DRAIN;
                DRAIN: begin
                    if (!bus.fb_allow && (count != '0)) state_d = STALL;
                    else if (will_empty)                 state_d = IDLE;
                end
                STALL:   if (bus.fb_allow) state_d = DRAIN;
                FLUSH:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_we_q    <= 1'b0;
            fb_x_q     <= '0;
            fb_y_q     <= '0;
            fb_color_q <= 1'b0;
        end else begin
            fb_we_q <= pop;
            if (pop) begin
                fb_x_q     <= head.x;
                fb_y_q     <= head.y;
                fb_color_q <= head.color;
            end
        end
    end

`ifdef PIXEL_CLIP_EN
    logic [CNT_W-1:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      drop_q <= '0;
        else if (push && off_screen && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.in_ready = ready;
    assign bus.count    = count;
    assign bus.empty    = (count == '0);
    assign bus.fb_we    = fb_we_q;
    assign bus.fb_x     = fb_x_q;
    assign bus.fb_y     = fb_y_q;
    assign bus.fb_color = fb_color_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// tb/tb_pixel_write_queue.sv - directed self-checking bench for pixel_write_queue
module tb_pixel_write_queue;
    import gfx_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_write_queue_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pixel_write_queue #(.DEPTH(DEPTH), .H_RES(800), .V_RES(600), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    pixel_t got[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.fb_we) got.push_back('{x: bus.fb_x, y: bus.fb_y, color: bus.fb_color});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_px(input int x, input int y, input bit c);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = 11'(x);
        bus.in_y     = 11'(y);
        bus.in_color = c;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check("push_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int b = 0;
        while (got.size() < n && b < 80) begin
            step();
            b++;
        end
    endtask

    initial begin
        int acc, first, last, sent, maxc, we_stall, we_run;
        bit prev_rdy, a;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_color = 1'b0;
        bus.flush = 1'b0; bus.fb_allow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.in_ready), 1);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_count", 32'(bus.count), 0);
        check("rst_fb_we", 32'(bus.fb_we), 0);
        check("rst_drop", 32'(bus.drop_cnt), 0);
        @(negedge clk) rst = 1'b0;
        step();

        // single pixel: accepted at next edge, write visible one edge later
        bus.fb_allow = 1'b1;
        bus.in_valid = 1'b1; bus.in_x = 11'd100; bus.in_y = 11'd100; bus.in_color = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("single_we_early", 32'(bus.fb_we), 0);
        check("single_count", 32'(bus.count), 1);
        step();
        check("single_we", 32'(bus.fb_we), 1);
        check("single_x", 32'(bus.fb_x), 100);
        check("single_y", 32'(bus.fb_y), 100);
        check("single_color", 32'(bus.fb_color), 1);
        check("single_empty", 32'(bus.empty), 1);
        step();
        check("single_we_off", 32'(bus.fb_we), 0);
        got.delete();

        // fill past capacity with writes blocked, then drain in order
        bus.fb_allow = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1; bus.in_x = 11'(i); bus.in_y = 11'(i + 100); bus.in_color = i[0];
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        check("full_accepts", 32'(acc), 16);
        check("full_count", 32'(bus.count), 16);
        check("full_ready", 32'(bus.in_ready), 0);
        check("full_state", 32'(dut.state_q), 32'(STALL));
        bus.fb_allow = 1'b1;
        first = -1; last = -1; prev_rdy = bus.in_ready;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.fb_we && first < 0) begin
                first = c;
                check("rdy_before_pop", 32'(prev_rdy), 0);
                check("rdy_after_pop", 32'(bus.in_ready), 1);
            end
            if (bus.fb_we) last = c;
            prev_rdy = bus.in_ready;
        end
        check("drain_span", 32'(last - first), 15);
        check("drain_n", 32'(got.size()), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            check("drain_x", 32'(got[i].x), 32'(i));
            check("drain_y", 32'(got[i].y), 32'(i + 100));
        end
        got.delete();

        // continuous stream with a 5-cycle grant gap
        sent = 0; maxc = 0; we_stall = 0; we_run = 0;
        for (int c = 0; c < 100 && sent < 30; c++) begin
            bus.fb_allow = (c < 10 || c >= 15);
            bus.in_valid = 1'b1; bus.in_x = 11'(200 + sent); bus.in_y = 11'(sent); bus.in_color = sent[0];
            a = bus.in_ready;
            step();
            if (a) sent++;
            if (c <= 9 && int'(bus.count) > maxc) maxc = int'(bus.count);
            if (c >= 1 && c <= 8) we_run += int'(bus.fb_we);
            if (c >= 9 && c <= 13) we_stall += int'(bus.fb_we);
            if (c == 12) check("stream_stall_state", 32'(dut.state_q), 32'(STALL));
        end
        bus.in_valid = 1'b0;
        bus.fb_allow = 1'b1;
        check("stream_max_count", 32'(maxc), 1);
        check("stream_rate", 32'(we_run), 8);
        check("stream_overhang", 32'(we_stall), 1);
        wait_writes(30);
        repeat (3) step();
        check("stream_n", 32'(got.size()), 30);
        for (int i = 0; i < 30 && i < got.size(); i++)
            check("stream_x", 32'(got[i].x), 32'(200 + i));
        got.delete();

        // flush with a coincident push
        bus.fb_allow = 1'b0;
        for (int i = 0; i < 8; i++) push_px(400 + i, 5, 1'b0);
        check("flush_pre_count", 32'(bus.count), 8);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_x = 11'd555; bus.in_y = 11'd55; bus.in_color = 1'b1;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("flush_count", 32'(bus.count), 0);
        check("flush_empty", 32'(bus.empty), 1);
        check("flush_fb_we", 32'(bus.fb_we), 0);
        check("flush_ready", 32'(bus.in_ready), 0);
        step();
        check("flush_idle", 32'(dut.state_q), 32'(IDLE));
        bus.fb_allow = 1'b1;
        repeat (10) step();
        check("flush_no_writes", 32'(got.size()), 0);
        got.delete();

        // clip boundary pixels
        push_px(799, 599, 1'b1);
        push_px(800, 10, 1'b0);
        push_px(10, 600, 1'b1);
        repeat (6) step();
`ifdef PIXEL_CLIP_EN
        check("clip_n", 32'(got.size()), 1);
        if (got.size() == 1) begin
            check("clip_x", 32'(got[0].x), 799);
            check("clip_y", 32'(got[0].y), 599);
        end
        check("clip_drop", 32'(bus.drop_cnt), 2);
`else
        check("noclip_n", 32'(got.size()), 3);
        if (got.size() == 3) begin
            check("noclip_x0", 32'(got[0].x), 799);
            check("noclip_x1", 32'(got[1].x), 800);
            check("noclip_y2", 32'(got[2].y), 600);
        end
        check("noclip_drop", 32'(bus.drop_cnt), 0);
`endif
        got.delete();

        // asynchronous reset in the middle of a drain
        bus.fb_allow = 1'b0;
        for (int i = 0; i < 5; i++) push_px(300 + i, 7, 1'b1);
        bus.fb_allow = 1'b1;
        first = 0;
        while (!bus.fb_we && first < 10) begin
            step();
            first++;
        end
        check("mid_drain_we", 32'(bus.fb_we), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_fb_we", 32'(bus.fb_we), 0);
        check("arst_fb_x", 32'(bus.fb_x), 0);
        check("arst_count", 32'(bus.count), 0);
        check("arst_empty", 32'(bus.empty), 1);
        check("arst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk) rst = 1'b0;
        step();
        check("post_rst_ready", 32'(bus.in_ready), 1);
        check("post_rst_empty", 32'(bus.empty), 1);
        check("post_rst_fb_we", 32'(bus.fb_we), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
